// File: rtl/policy_cfg_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | policy_cfg_pkg                                                         |
// | Address map, response FSM states and helpers for policy_cfg_regs.      |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package policy_cfg_pkg;

   localparam logic [11:0] APU_BASE   = 12'h000;
   localparam logic [11:0] DPU_BASE   = 12'h400;
   localparam logic [11:0] CTRL_OFS   = 12'h800;
   localparam logic [11:0] STATUS_OFS = 12'h804;
   localparam logic [11:0] APU_STRIDE = 12'h010;
   localparam logic [11:0] DPU_STRIDE = 12'h020;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      ERR1 = 2'd2,
      ERR2 = 2'd3
   } ahb_state_e;

   typedef struct packed {
      logic       apu;
      logic       dpu;
      logic       ctrl;
      logic       status;
      logic [5:0] slot;
      logic [2:0] idx;
   } reg_sel_t;

   function automatic logic is_trusted(input logic [31:0] hmaster);
      return (hmaster & 32'hFFFF_FFFE) == 32'h0;
   endfunction

   // Word address -> region/slot/register; range checks against the slot
   // counts are left to the caller, which owns the parameters.
   function automatic reg_sel_t decode_addr(input logic [11:2] a);
      reg_sel_t s;
      s = '0;
      if (a[11:10] == APU_BASE[11:10]) begin
         s.apu  = 1'b1;
         s.slot = 6'({a[9:2], 2'b00} / APU_STRIDE[9:0]);
         s.idx  = {1'b0, a[3:2]};
      end else if (a[11:10] == DPU_BASE[11:10]) begin
         s.dpu  = 1'b1;
         s.slot = 6'({a[9:2], 2'b00} / DPU_STRIDE[9:0]);
         s.idx  = a[4:2];
      end else begin
         s.ctrl   = ({a, 2'b00} == CTRL_OFS);
         s.status = ({a, 2'b00} == STATUS_OFS);
      end
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/policy_cfg_regs_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | policy_cfg_regs_if                                                     |
// | AHB-Lite config bus between a master and the policy register bank.    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
interface policy_cfg_regs_if;
   logic        hsel;
   logic [31:0] haddr;
   logic [31:0] hmaster;
   logic [2:0]  hsize;
   logic        hwrite;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;

   modport master (
      output hsel, haddr, hmaster, hsize, hwrite, hwdata,
      input  hrdata, hready, hresp
   );

   modport slave (
      input  hsel, haddr, hmaster, hsize, hwrite, hwdata,
      output hrdata, hready, hresp
   );
endinterface
`default_nettype wire

// File: rtl/policy_ahb_resp.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | policy_ahb_resp                                                        |
// | hready/hresp sequencer: zero-wait OKAY or two-cycle ERROR response.    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module policy_ahb_resp
   import policy_cfg_pkg::*;
(
   input  logic hclk,
   input  logic hresetn,
   input  logic addr_valid_i,
   input  logic illegal_i,
   output logic hready_o,
   output logic hresp_o,
   output logic data_ok_o
);

   ahb_state_e state_q;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q   <= IDLE;
         hready_o  <= 1'b1;
         hresp_o   <= 1'b0;
         data_ok_o <= 1'b0;
      end else begin
         case (state_q)
            ERR1: begin
               state_q   <= ERR2;
               hready_o  <= 1'b1;
               hresp_o   <= 1'b1;
               data_ok_o <= 1'b0;
            end
            // IDLE, DATA and ERR2 all accept the next address phase
            default: begin
               if (addr_valid_i && illegal_i) begin
                  state_q   <= ERR1;
                  hready_o  <= 1'b0;
                  hresp_o   <= 1'b1;
                  data_ok_o <= 1'b0;
               end else if (addr_valid_i) begin
                  state_q   <= DATA;
                  hready_o  <= 1'b1;
                  hresp_o   <= 1'b0;
                  data_ok_o <= 1'b1;
               end else begin
                  state_q   <= IDLE;
                  hready_o  <= 1'b1;
                  hresp_o   <= 1'b0;
                  data_ok_o <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/policy_cfg_regs.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | policy_cfg_regs                                                        |
// | AHB-Lite APU/DPU policy table bank with sticky LOCK and deny counter.  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module policy_cfg_regs
   import policy_cfg_pkg::*;
#(
   parameter int NUM_APU_POLICY = 16,
   parameter int NUM_DPU_POLICY = 16
) (
   input  logic                             hclk,
   input  logic                             hresetn,
   policy_cfg_regs_if.slave                 bus,
   output logic [NUM_APU_POLICY-1:0][31:0]  apumid,
   output logic [NUM_APU_POLICY-1:0][31:0]  apuaddr,
   output logic [NUM_APU_POLICY-1:0][31:0]  apumask,
   output logic [NUM_APU_POLICY-1:0][31:0]  apuperm,
   output logic [NUM_DPU_POLICY-1:0][31:0]  dpumid,
   output logic [NUM_DPU_POLICY-1:0][31:0]  dpuaddr,
   output logic [NUM_DPU_POLICY-1:0][31:0]  dpudata,
   output logic [NUM_DPU_POLICY-1:0][31:0]  dpumask,
   output logic [NUM_DPU_POLICY-1:0][31:0]  dpuamask
);

   logic [NUM_APU_POLICY-1:0][31:0] apumid_q, apuaddr_q, apumask_q, apuperm_q;
   logic [NUM_DPU_POLICY-1:0][31:0] dpumid_q, dpuaddr_q, dpudata_q, dpumask_q, dpuamask_q;

   logic        addr_valid, illegal, data_ok, wr_en, rd_en;
   logic        trusted, mapped, rw_ok, lock_blk;
   reg_sel_t    sel_a, sel_q;
   logic [11:2] addr_q;
   logic        write_q, lock_q;
   logic [15:0] deny_cnt_q, deny_cnt_d;
   logic [31:0] rdata;
   logic        unused_haddr;

   assign unused_haddr = ^bus.haddr[31:12];

   // Address-phase legality
   assign addr_valid = bus.hsel & bus.hready;
   assign sel_a      = decode_addr(bus.haddr[11:2]);
   assign trusted    = is_trusted(bus.hmaster);
   assign mapped     = (sel_a.apu && (int'(sel_a.slot) < NUM_APU_POLICY))
                     || (sel_a.dpu && (sel_a.idx <= 3'd4) && (int'(sel_a.slot) < NUM_DPU_POLICY))
                     || sel_a.ctrl || sel_a.status;
   assign rw_ok      = trusted | ((sel_a.ctrl | sel_a.status) & ~bus.hwrite);
   assign lock_blk   = lock_q & bus.hwrite & (sel_a.apu | sel_a.dpu | sel_a.ctrl);
   assign illegal    = ~mapped | (bus.haddr[1:0] != 2'b00) | (bus.hsize != 3'b010)
                     | ~rw_ok | lock_blk;

   policy_ahb_resp u_resp (
      .hclk         (hclk),
      .hresetn      (hresetn),
      .addr_valid_i (addr_valid),
      .illegal_i    (illegal),
      .hready_o     (bus.hready),
      .hresp_o      (bus.hresp),
      .data_ok_o    (data_ok)
   );

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         addr_q  <= '0;
         write_q <= 1'b0;
      end else if (addr_valid) begin
         addr_q  <= bus.haddr[11:2];
         write_q <= bus.hwrite;
      end
   end

   assign sel_q = decode_addr(addr_q);
   assign wr_en = data_ok & write_q;
   assign rd_en = data_ok & ~write_q;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         apumid_q <= '0; apuaddr_q <= '0; apumask_q <= '0; apuperm_q <= '0;
         dpumid_q <= '0; dpuaddr_q <= '0; dpudata_q <= '0; dpumask_q <= '0;
         dpuamask_q <= '0;
         lock_q   <= 1'b0;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_APU_POLICY; i++) begin
            if (sel_q.apu && (int'(sel_q.slot) == i)) begin
               case (sel_q.idx)
                  3'd0:    apumid_q[i]  <= bus.hwdata;
                  3'd1:    apuaddr_q[i] <= bus.hwdata;
                  3'd2:    apumask_q[i] <= bus.hwdata;
                  default: apuperm_q[i] <= bus.hwdata;
               endcase
            end
         end
         for (int j = 0; j < NUM_DPU_POLICY; j++) begin
            if (sel_q.dpu && (int'(sel_q.slot) == j)) begin
               case (sel_q.idx)
                  3'd0:    dpumid_q[j]   <= bus.hwdata;
                  3'd1:    dpuaddr_q[j]  <= bus.hwdata;
                  3'd2:    dpudata_q[j]  <= bus.hwdata;
                  3'd3:    dpumask_q[j]  <= bus.hwdata;
                  default: dpuamask_q[j] <= bus.hwdata;
               endcase
            end
         end
         // LOCK is sticky; writing 0 never clears it
         if (sel_q.ctrl && bus.hwdata[0]) lock_q <= 1'b1;
      end
   end

   // A STATUS clear beats a deny increment landing in the same cycle
   always_comb begin
      deny_cnt_d = deny_cnt_q;
      if (wr_en && sel_q.status)
         deny_cnt_d = '0;
      else if (addr_valid && illegal && (deny_cnt_q != 16'hFFFF))
         deny_cnt_d = deny_cnt_q + 16'd1;
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) deny_cnt_q <= '0;
      else          deny_cnt_q <= deny_cnt_d;
   end

   always_comb begin
      rdata = '0;
      if (rd_en) begin
         if (sel_q.ctrl)   rdata = {31'b0, lock_q};
         if (sel_q.status) rdata = {16'b0, deny_cnt_q};
         for (int i = 0; i < NUM_APU_POLICY; i++) begin
            if (sel_q.apu && (int'(sel_q.slot) == i)) begin
               case (sel_q.idx)
                  3'd0:    rdata = apumid_q[i];
                  3'd1:    rdata = apuaddr_q[i];
                  3'd2:    rdata = apumask_q[i];
                  default: rdata = apuperm_q[i];
               endcase
            end
         end
         for (int j = 0; j < NUM_DPU_POLICY; j++) begin
            if (sel_q.dpu && (int'(sel_q.slot) == j)) begin
               case (sel_q.idx)
                  3'd0:    rdata = dpumid_q[j];
                  3'd1:    rdata = dpuaddr_q[j];
                  3'd2:    rdata = dpudata_q[j];
                  3'd3:    rdata = dpumask_q[j];
                  default: rdata = dpuamask_q[j];
               endcase
            end
         end
      end
   end

   assign bus.hrdata = rdata;

   assign apumid   = apumid_q;
   assign apuaddr  = apuaddr_q;
   assign apumask  = apumask_q;
   assign apuperm  = apuperm_q;
   assign dpumid   = dpumid_q;
   assign dpuaddr  = dpuaddr_q;
   assign dpudata  = dpudata_q;
   assign dpumask  = dpumask_q;
   assign dpuamask = dpuamask_q;

endmodule
`default_nettype wire

// File: tb/tb_policy_cfg_regs.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_policy_cfg_regs                                                     |
// | Directed self-checking bench for the policy config register bank.      |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_policy_cfg_regs;

   localparam int          NAPU   = 16;
   localparam int          NDPU   = 16;
   // Response code {hready,hresp} of data cycle 1, then of cycle 2
   localparam logic [31:0] RSP_OK  = 32'h8;
   localparam logic [31:0] RSP_ERR = 32'h7;

   logic hclk    = 1'b0;
   logic hresetn = 1'b0;
   always #5 hclk = ~hclk;

   policy_cfg_regs_if bus();

   logic [NAPU-1:0][31:0] apumid, apuaddr, apumask, apuperm;
   logic [NDPU-1:0][31:0] dpumid, dpuaddr, dpudata, dpumask, dpuamask;

   int n_vec  = 0;
   int n_miss = 0;

   logic [31:0] rdv, rspv;

   policy_cfg_regs #(
      .NUM_APU_POLICY (NAPU),
      .NUM_DPU_POLICY (NDPU)
   ) dut (
      .hclk     (hclk),
      .hresetn  (hresetn),
      .bus      (bus),
      .apumid   (apumid),
      .apuaddr  (apuaddr),
      .apumask  (apumask),
      .apuperm  (apuperm),
      .dpumid   (dpumid),
      .dpuaddr  (dpuaddr),
      .dpudata  (dpudata),
      .dpumask  (dpumask),
      .dpuamask (dpuamask)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One isolated transfer; entered and left at posedge+1 with the bus idle
   task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [31:0] m, input logic [2:0] sz,
                       output logic [31:0] rdo, output logic [31:0] rsp);
      logic [1:0] ph1, ph2;
      bus.hsel = 1'b1; bus.haddr = a; bus.hwrite = w; bus.hmaster = m; bus.hsize = sz;
      @(posedge hclk); #1;
      bus.hsel   = 1'b0;
      bus.hwdata = wd;
      rdo = bus.hrdata;
      ph1 = {bus.hready, bus.hresp};
      ph2 = 2'b00;
      if (!bus.hready) begin
         @(posedge hclk); #1;
         ph2 = {bus.hready, bus.hresp};
      end
      @(posedge hclk); #1;
      rsp = {28'b0, ph1, ph2};
   endtask

   task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] m, input logic [31:0] exp_rsp);
      logic [31:0] r, s;
      xfer(a, 1'b1, d, m, 3'b010, r, s);
      check({tag, "_rsp"}, s, exp_rsp);
      check({tag, "_hrdata"}, r, 32'h0);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] m,
                         input logic [31:0] exp_rsp, input logic [31:0] exp_data);
      logic [31:0] r, s;
      xfer(a, 1'b0, 32'h0, m, 3'b010, r, s);
      check({tag, "_rsp"}, s, exp_rsp);
      check({tag, "_data"}, r, exp_data);
   endtask

   initial begin
      bus.hsel = 1'b0; bus.haddr = '0; bus.hmaster = '0; bus.hsize = 3'b010;
      bus.hwrite = 1'b0; bus.hwdata = '0;
      hresetn = 1'b0;
      repeat (3) @(posedge hclk);
      #1;
      check("rst_hready", {31'b0, bus.hready}, 32'h1);
      check("rst_hresp",  {31'b0, bus.hresp},  32'h0);
      check("rst_hrdata", bus.hrdata, 32'h0);
      check("rst_apuaddr0", apuaddr[0], 32'h0);
      hresetn = 1'b1;
      @(posedge hclk); #1;

      // Trusted write and read-back of APU0.ADDR
      wr_chk("t1_wr", 32'h004, 32'h1000_0000, 32'h0, RSP_OK);
      check("t1_apuaddr0", apuaddr[0], 32'h1000_0000);
      rd_chk("t1_rd", 32'h004, 32'h0, RSP_OK, 32'h1000_0000);

      // Back-to-back write then read of APU1.MID
      bus.hsel = 1'b1; bus.haddr = 32'h010; bus.hwrite = 1'b1; bus.hmaster = 32'h0;
      bus.hsize = 3'b010;
      @(posedge hclk); #1;
      bus.hwdata = 32'hA5A5_5A5A; bus.hwrite = 1'b0;
      @(posedge hclk); #1;
      bus.hsel = 1'b0;
      check("b2b_rsp", {30'b0, bus.hready, bus.hresp}, 32'h2);
      check("b2b_rd", bus.hrdata, 32'hA5A5_5A5A);
      @(posedge hclk); #1;
      check("b2b_apumid1", apumid[1], 32'hA5A5_5A5A);

      // Untrusted write is denied
      wr_chk("t2_wr", 32'h01C, 32'h3, 32'h5, RSP_ERR);
      check("t2_apuperm1", apuperm[1], 32'h0);
      rd_chk("t2_status", 32'h804, 32'h0, RSP_OK, 32'h1);
      rd_chk("t2_status_untr", 32'h804, 32'h5, RSP_OK, 32'h1);

      // LOCK freezes the tables; STATUS clear still allowed
      wr_chk("t3_lock", 32'h800, 32'h1, 32'h0, RSP_OK);
      wr_chk("t3_dpu2", 32'h448, 32'hDEAD_BEEF, 32'h0, RSP_ERR);
      check("t3_dpudata2", dpudata[2], 32'h0);
      rd_chk("t3_ctrl", 32'h800, 32'h0, RSP_OK, 32'h1);
      rd_chk("t3_status", 32'h804, 32'h0, RSP_OK, 32'h2);
      wr_chk("t3_clr", 32'h804, 32'h1234, 32'h0, RSP_OK);
      rd_chk("t3_status0", 32'h804, 32'h0, RSP_OK, 32'h0);

      // Size, alignment, gap and slot-range errors
      xfer(32'h000, 1'b1, 32'h55, 32'h0, 3'b001, rdv, rspv);
      check("t4_hsize_rsp", rspv, RSP_ERR);
      wr_chk("t4_misalign", 32'h002, 32'h66, 32'h0, RSP_ERR);
      rd_chk("t4_dpu_gap", 32'h414, 32'h0, RSP_ERR, 32'h0);
      rd_chk("t4_status", 32'h804, 32'h0, RSP_OK, 32'h3);
      rd_chk("t4_apu_slot16", 32'h100, 32'h0, RSP_ERR, 32'h0);
      rd_chk("t4_dpu_slot16", 32'h600, 32'h0, RSP_ERR, 32'h0);
      rd_chk("t4_apu15", 32'h0FC, 32'h0, RSP_OK, 32'h0);
      rd_chk("t4_status5", 32'h804, 32'h0, RSP_OK, 32'h5);

      // 0x10000 pipelined illegal accesses, two cycles each
      bus.hsel = 1'b1; bus.haddr = 32'h000; bus.hwrite = 1'b0; bus.hmaster = 32'h0;
      bus.hsize = 3'b001;
      repeat (2 * 65536) @(posedge hclk);
      #1;
      rd_chk("t5_sat", 32'h804, 32'h0, RSP_OK, 32'h0000_FFFF);

      // Reset in the middle of ERR1
      bus.hsel = 1'b1; bus.haddr = 32'h000; bus.hwrite = 1'b0; bus.hsize = 3'b001;
      @(posedge hclk); #1;
      check("t5_err1_hready", {31'b0, bus.hready}, 32'h0);
      hresetn = 1'b0;
      #1;
      check("t5_rst_hready", {31'b0, bus.hready}, 32'h1);
      check("t5_rst_hresp",  {31'b0, bus.hresp},  32'h0);
      check("t5_rst_hrdata", bus.hrdata, 32'h0);
      check("t5_rst_apumid1", apumid[1], 32'h0);
      check("t5_rst_apuaddr0", apuaddr[0], 32'h0);
      bus.hsel = 1'b0; bus.hsize = 3'b010;
      repeat (2) @(posedge hclk);
      #1;
      hresetn = 1'b1;
      @(posedge hclk); #1;
      rd_chk("t5_ctrl", 32'h800, 32'h0, RSP_OK, 32'h0);
      rd_chk("t5_status", 32'h804, 32'h0, RSP_OK, 32'h0);

      // Writing 0 to CTRL while unlocked leaves LOCK clear
      wr_chk("t6_ctrl0", 32'h800, 32'h0, 32'h0, RSP_OK);
      rd_chk("t6_ctrl", 32'h800, 32'h0, RSP_OK, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
